i_set_waveform_gen: RTL and testbench
=====================================

I_SET_WAVEFORM_GEN -- requirements
Module: i_set_waveform_gen

Interface
REQ-001 Parameter IW, default 16, width of the current setpoint and of Ip.
REQ-002 Parameter TW, default 32, width of the timing inputs and the internal pulse timer.
REQ-003 Parameter FRAC, default 16, number of fractional bits in the ramp accumulator.
REQ-004 clk  in  1  system clock; the block has one clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin one discharge pulse.
REQ-007 abort  in  1  terminate the current pulse immediately.
REQ-008 waveform  in  16  mode code: 0x2001 or 0x6001 rectangle, 0x2002 triangle, 0x2004 trapezoid.
REQ-009 Ip  in  IW  peak current.
REQ-010 Ton_timer  in  TW  pulse length in clk cycles.
REQ-011 Tramp  in  TW  trapezoid ramp length in clk cycles.
REQ-012 i_set  out  IW  registered current setpoint.
REQ-013 busy  out  1  high while a pulse is in progress.
REQ-014 done  out  1  one-cycle pulse when a pulse completes normally.
REQ-015 bad_mode  out  1  one-cycle pulse when start is seen with an unsupported waveform code.

Function
REQ-016 States: IDLE, CALC, RISE, HOLD, FALL.
- Leaving IDLE goes to the first non-empty phase: RISE or HOLD, or CALC when a step is needed.
REQ-017 In IDLE, start=1 with a supported code latches waveform, Ip, Ton_timer and Tramp; later input changes have no effect until the next start.
REQ-018 start with an unsupported code, or while busy=1, is ignored.
- bad_mode pulses the next cycle for an unsupported code seen in IDLE.
REQ-019 Phase lengths:
- Rectangle: HOLD = Ton.
- Triangle: RISE = Ton>>1, FALL = Ton - (Ton>>1), HOLD = 0.
- Trapezoid: RISE = FALL = Tramp, HOLD = Ton - 2*Tramp.
- Trapezoid with 2*Tramp >= Ton is treated as triangle.
REQ-020 Ramp step = (Ip << FRAC) / ramp_len, computed once per pulse in CALC by the sequential divider.
- CALC lasts exactly IW+FRAC cycles.
- CALC is skipped for rectangle and whenever ramp_len = 0.
REQ-021 RISE: the accumulator adds step each cycle and i_set = acc >> FRAC.
- On the last RISE cycle, acc is forced to Ip << FRAC, so i_set = Ip exactly.
REQ-022 HOLD: i_set = Ip.
REQ-023 FALL: the accumulator subtracts step each cycle and saturates at 0.
- On the last FALL cycle, i_set = 0.
REQ-024 A phase of length 0 is skipped with no dead cycle.
- Ton = 0: done pulses the cycle after start, i_set stays 0 and busy stays 0.
REQ-025 Rectangle timing: start at cycle 0 gives i_set = Ip for cycles 1..Ton, then i_set = 0, busy falls and done = 1, all in cycle Ton+1.
REQ-026 busy = 1 in every non-IDLE state.
REQ-027 abort = 1 in any state gives i_set = 0 and state IDLE on the next cycle, with no done pulse.
- abort and start in the same cycle: abort wins.
REQ-028 i_set never exceeds the latched Ip.
- Arithmetic is unsigned.
- The internal pulse timer is TW bits and never wraps within a pulse.

Reset
REQ-029 While rst_n = 0, asynchronously: state = IDLE; i_set, busy, done, bad_mode, the accumulator, the timer and the latched parameters are 0.
REQ-030 Reset asserted mid-pulse abandons the pulse; no done is produced after release.

Configuration
REQ-031 Macro ISET_TRAPEZOID_EN defined: code 0x2004 is supported and the Tramp input is used.
REQ-032 Macro ISET_TRAPEZOID_EN undefined: 0x2004 is unsupported (bad_mode), Tramp is ignored, and no trapezoid logic is synthesised.

Structure
REQ-033 A shared package holds:
- the waveform code constants 0x2001, 0x6001, 0x2002, 0x2004;
- the state encoding;
- the default values of IW, TW and FRAC.
REQ-034 Sub-module iset_seq_div: an unsigned restoring divider, one quotient bit per cycle, with a start/done handshake; it is instantiated once.

Verification
REQ-035 Rectangle: waveform = 0x2001, Ip = 1000, Ton = 10 -> i_set = 1000 for exactly 10 cycles, done in cycle 11, i_set = 0 afterwards.
REQ-036 Triangle: waveform = 0x2002, Ip = 800, Ton = 8 -> after 32 CALC cycles, RISE gives 200, 400, 600, 800; FALL gives 600, 400, 200, 0; done with the final 0.
REQ-037 Trapezoid (macro on): waveform = 0x2004, Ip = 500, Ton = 10, Tramp = 2 -> RISE 250, 500; HOLD 500 for 6 cycles; FALL 250, 0.
- Same stimulus with the macro off -> bad_mode pulse, i_set stays 0.
REQ-038 Boundaries:
- Ton = 0 -> done one cycle after start, busy stays 0.
- Triangle with Ton = 1 -> CALC skipped, RISE length 0, one FALL cycle, i_set = 0.
- Trapezoid with Tramp = 6, Ton = 10 -> behaves as triangle.
REQ-039 abort in the 3rd HOLD cycle of a rectangle -> i_set = 0 and busy = 0 the next cycle, no done.
- start while busy -> ignored, the latched Ip is unchanged.
REQ-040 rst_n pulsed low mid-RISE -> all outputs 0 immediately; after release, the next start runs a complete correct pulse.

Source files
------------

// File: rtl/i_set_waveform_gen_pkg.sv
// Shared definitions for the discharge-current waveform generator.
// ISET_TRAPEZOID_EN enables the trapezoid code (0x2004).
package i_set_waveform_gen_pkg;

    localparam int IW_DEF   = 16;
    localparam int TW_DEF   = 32;
    localparam int FRAC_DEF = 16;

    localparam logic [15:0] WF_RECT     = 16'h2001;
    localparam logic [15:0] WF_RECT_ALT = 16'h6001;
    localparam logic [15:0] WF_TRI      = 16'h2002;
    localparam logic [15:0] WF_TRAP     = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_RISE = 3'd2,
        ST_HOLD = 3'd3,
        ST_FALL = 3'd4
    } state_t;

    function automatic logic is_supported(input logic [15:0] code);
        logic ok;
        case (code)
            WF_RECT, WF_RECT_ALT, WF_TRI: ok = 1'b1;
`ifdef ISET_TRAPEZOID_EN
            WF_TRAP:                      ok = 1'b1;
`endif
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/i_set_waveform_gen_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
// The first bit is resolved on the start edge, so done pulses DW cycles after start.
module iset_seq_div
    import i_set_waveform_gen_pkg::*;
#(
    parameter int DW = 32,
    parameter int VW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);

    localparam int CW = $clog2(DW + 1);

    logic [VW-1:0] rem_r;
    logic [DW-1:0] quo_r;
    logic [VW-1:0] dvs_r;
    logic [CW-1:0] cnt_r;
    logic          done_r;
    logic [VW-1:0] rem_n_s;
    logic [DW-1:0] quo_n_s;

    function automatic logic [VW+DW-1:0] div_step(input logic [VW-1:0] rem,
                                                  input logic [DW-1:0] quo,
                                                  input logic [VW-1:0] dvs);
        logic [VW:0] sh;
        logic [VW+DW-1:0] res;
        sh = {rem, quo[DW-1]};
        if (sh >= {1'b0, dvs}) begin
            res = {sh[VW-1:0] - dvs, quo[DW-2:0], 1'b1};
        end else begin
            res = {sh[VW-1:0], quo[DW-2:0], 1'b0};
        end
        return res;
    endfunction

    // One restoring step, seeded from the operands on start.
    always_comb begin
        if (start) begin
            {rem_n_s, quo_n_s} = div_step({VW{1'b0}}, dividend, divisor);
        end else begin
            {rem_n_s, quo_n_s} = div_step(rem_r, quo_r, dvs_r);
        end
    end

    // Iteration counter and partial remainder/quotient registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {VW{1'b0}};
            quo_r  <= {DW{1'b0}};
            dvs_r  <= {VW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_n_s;
            quo_r  <= quo_n_s;
            dvs_r  <= divisor;
            cnt_r  <= CW'(DW - 1);
            done_r <= (DW == 1);
        end else if (cnt_r != {CW{1'b0}}) begin
            rem_r  <= rem_n_s;
            quo_r  <= quo_n_s;
            cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            done_r <= (cnt_r == {{(CW-1){1'b0}}, 1'b1});
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = quo_r;
    assign done     = done_r;

endmodule

// File: rtl/i_set_waveform_gen.sv
// Current-setpoint waveform generator: rectangle, triangle and (with
// ISET_TRAPEZOID_EN defined) trapezoid pulses built from RISE/HOLD/FALL phases.
module i_set_waveform_gen
    import i_set_waveform_gen_pkg::*;
#(
    parameter int IW   = IW_DEF,
    parameter int TW   = TW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   waveform,
    input  logic [IW-1:0] Ip,
    input  logic [TW-1:0] Ton_timer,
    input  logic [TW-1:0] Tramp,
    output logic [IW-1:0] i_set,
    output logic          busy,
    output logic          done,
    output logic          bad_mode
);

    localparam int DW = IW + FRAC;
    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
    localparam logic [IW-1:0] I_ZERO = {IW{1'b0}};

    state_t        state_r;
    logic [IW-1:0] i_set_r;
    logic          busy_r;
    logic          done_r;
    logic          bad_mode_r;
    logic [DW-1:0] acc_r;
    logic [DW-1:0] step_r;
    logic [TW-1:0] timer_r;
    logic [IW-1:0] ip_r;
    logic [TW-1:0] rise_r;
    logic [TW-1:0] hold_r;
    logic [TW-1:0] fall_r;

    logic [TW-1:0] rise_s;
    logic [TW-1:0] hold_s;
    logic [TW-1:0] fall_s;
    logic          sup_s;
    logic          div_start_s;
    logic          div_done_s;
    logic [DW-1:0] quot_s;
    logic [DW-1:0] ip_fix_s;
    logic [DW-1:0] acc_up_s;
    logic [DW-1:0] acc_dn_s;
    logic [DW-1:0] fall_first_s;

`ifndef ISET_TRAPEZOID_EN
    logic [TW-1:0] unused_tramp_s;
    assign unused_tramp_s = Tramp;
`endif

    // Phase lengths for the code currently on the inputs.
    always_comb begin
        rise_s = T_ZERO;
        hold_s = T_ZERO;
        fall_s = T_ZERO;
        case (waveform)
            WF_RECT, WF_RECT_ALT: hold_s = Ton_timer;
            WF_TRI: begin
                rise_s = Ton_timer >> 1;
                fall_s = Ton_timer - (Ton_timer >> 1);
            end
`ifdef ISET_TRAPEZOID_EN
            WF_TRAP: begin
                if ({Tramp, 1'b0} >= {1'b0, Ton_timer}) begin
                    rise_s = Ton_timer >> 1;
                    fall_s = Ton_timer - (Ton_timer >> 1);
                end else begin
                    rise_s = Tramp;
                    hold_s = Ton_timer - {Tramp[TW-2:0], 1'b0};
                    fall_s = Tramp;
                end
            end
`endif
            default: hold_s = T_ZERO;
        endcase
    end

    assign sup_s        = is_supported(waveform);
    assign div_start_s  = (state_r == ST_IDLE) && start && !abort && sup_s && (rise_s != T_ZERO);
    assign ip_fix_s     = {ip_r, {FRAC{1'b0}}};
    assign acc_up_s     = acc_r + step_r;
    assign acc_dn_s     = (acc_r >= step_r) ? (acc_r - step_r) : D_ZERO;
    assign fall_first_s = (ip_fix_s >= step_r) ? (ip_fix_s - step_r) : D_ZERO;

    iset_seq_div #(
        .DW (DW),
        .VW (TW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend ({Ip, {FRAC{1'b0}}}),
        .divisor  (rise_s),
        .quotient (quot_s),
        .done     (div_done_s)
    );

    // Pulse sequencer; timer_r holds the cycles left in the current phase minus one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            i_set_r    <= I_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bad_mode_r <= 1'b0;
            acc_r      <= D_ZERO;
            step_r     <= D_ZERO;
            timer_r    <= T_ZERO;
            ip_r       <= I_ZERO;
            rise_r     <= T_ZERO;
            hold_r     <= T_ZERO;
            fall_r     <= T_ZERO;
        end else begin
            done_r     <= 1'b0;
            bad_mode_r <= 1'b0;
            if (abort) begin
                state_r <= ST_IDLE;
                i_set_r <= I_ZERO;
                busy_r  <= 1'b0;
                acc_r   <= D_ZERO;
                timer_r <= T_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start && !sup_s) begin
                            bad_mode_r <= 1'b1;
                        end else if (start) begin
                            ip_r   <= Ip;
                            rise_r <= rise_s;
                            hold_r <= hold_s;
                            fall_r <= fall_s;
                            step_r <= D_ZERO;
                            acc_r  <= D_ZERO;
                            if (rise_s != T_ZERO) begin
                                state_r <= ST_CALC;
                                busy_r  <= 1'b1;
                            end else if (hold_s != T_ZERO) begin
                                state_r <= ST_HOLD;
                                busy_r  <= 1'b1;
                                i_set_r <= Ip;
                                timer_r <= hold_s - T_ONE;
                            end else if (fall_s != T_ZERO) begin
                                state_r <= ST_FALL;
                                busy_r  <= 1'b1;
                                acc_r   <= {Ip, {FRAC{1'b0}}};
                                i_set_r <= (fall_s == T_ONE) ? I_ZERO : Ip;
                                timer_r <= fall_s - T_ONE;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    ST_CALC: begin
                        if (div_done_s) begin
                            step_r  <= quot_s;
                            state_r <= ST_RISE;
                            timer_r <= rise_r - T_ONE;
                            if (rise_r == T_ONE) begin
                                acc_r   <= ip_fix_s;
                                i_set_r <= ip_r;
                            end else begin
                                acc_r   <= quot_s;
                                i_set_r <= quot_s[DW-1:FRAC];
                            end
                        end
                    end
                    ST_RISE: begin
                        if (timer_r != T_ZERO) begin
                            timer_r <= timer_r - T_ONE;
                            // Final rise step lands exactly on Ip regardless of step rounding.
                            if (timer_r == T_ONE) begin
                                acc_r   <= ip_fix_s;
                                i_set_r <= ip_r;
                            end else begin
                                acc_r   <= acc_up_s;
                                i_set_r <= acc_up_s[DW-1:FRAC];
                            end
                        end else if (hold_r != T_ZERO) begin
                            state_r <= ST_HOLD;
                            i_set_r <= ip_r;
                            timer_r <= hold_r - T_ONE;
                        end else if (fall_r != T_ZERO) begin
                            state_r <= ST_FALL;
                            timer_r <= fall_r - T_ONE;
                            acc_r   <= (fall_r == T_ONE) ? D_ZERO : fall_first_s;
                            i_set_r <= (fall_r == T_ONE) ? I_ZERO : fall_first_s[DW-1:FRAC];
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            i_set_r <= I_ZERO;
                            acc_r   <= D_ZERO;
                        end
                    end
                    ST_HOLD: begin
                        if (timer_r != T_ZERO) begin
                            timer_r <= timer_r - T_ONE;
                        end else if (fall_r != T_ZERO) begin
                            state_r <= ST_FALL;
                            timer_r <= fall_r - T_ONE;
                            acc_r   <= (fall_r == T_ONE) ? D_ZERO : fall_first_s;
                            i_set_r <= (fall_r == T_ONE) ? I_ZERO : fall_first_s[DW-1:FRAC];
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            i_set_r <= I_ZERO;
                            acc_r   <= D_ZERO;
                        end
                    end
                    ST_FALL: begin
                        if (timer_r != T_ZERO) begin
                            timer_r <= timer_r - T_ONE;
                            if (timer_r == T_ONE) begin
                                acc_r   <= D_ZERO;
                                i_set_r <= I_ZERO;
                            end else begin
                                acc_r   <= acc_dn_s;
                                i_set_r <= acc_dn_s[DW-1:FRAC];
                            end
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            i_set_r <= I_ZERO;
                            acc_r   <= D_ZERO;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        i_set_r <= I_ZERO;
                        acc_r   <= D_ZERO;
                    end
                endcase
            end
        end
    end

    assign i_set    = i_set_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign bad_mode = bad_mode_r;

endmodule

// File: tb/tb_i_set_waveform_gen.sv
// Randomized self-checking bench for i_set_waveform_gen against a cycle-list reference model.
module tb_i_set_waveform_gen;

    localparam int IW   = 16;
    localparam int TW   = 32;
    localparam int FRAC = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [15:0]   waveform;
    logic [IW-1:0] Ip;
    logic [TW-1:0] Ton_timer;
    logic [TW-1:0] Tramp;
    logic [IW-1:0] i_set;
    logic          busy;
    logic          done;
    logic          bad_mode;

    int n_cmp = 0;
    int n_err = 0;

    longint exp_iset[$];
    bit     exp_busy[$];
    bit     exp_done[$];
    bit     exp_bad[$];
    longint obs_iset[$];

    i_set_waveform_gen #(.IW(IW), .TW(TW), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .waveform  (waveform),
        .Ip        (Ip),
        .Ton_timer (Ton_timer),
        .Tramp     (Tramp),
        .i_set     (i_set),
        .busy      (busy),
        .done      (done),
        .bad_mode  (bad_mode)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit code_ok(input logic [15:0] code);
        bit ok;
        ok = (code == 16'h2001) || (code == 16'h6001) || (code == 16'h2002);
`ifdef ISET_TRAPEZOID_EN
        ok = ok || (code == 16'h2004);
`endif
        return ok;
    endfunction

    task automatic push_exp(input longint v, input bit b, input bit d, input bit bm);
        exp_iset.push_back(v);
        exp_busy.push_back(b);
        exp_done.push_back(d);
        exp_bad.push_back(bm);
    endtask

    // Expected outputs for cycles 1,2,... after the start cycle, plus one idle cycle.
    task automatic build_model(input logic [15:0] mode, input longint ip,
                               input longint ton, input longint tramp);
        longint r, h, f, full, step, v;
        int calc;
        exp_iset.delete(); exp_busy.delete(); exp_done.delete(); exp_bad.delete();
        if (!code_ok(mode)) begin
            push_exp(0, 1'b0, 1'b0, 1'b1);
            push_exp(0, 1'b0, 1'b0, 1'b0);
            return;
        end
        r = 0; h = 0; f = 0;
        if (mode == 16'h2001 || mode == 16'h6001) begin
            h = ton;
        end else if (mode == 16'h2002 || 2 * tramp >= ton) begin
            r = ton / 2;
            f = ton - r;
        end else begin
            r = tramp;
            f = tramp;
            h = ton - 2 * tramp;
        end
        full = ip << FRAC;
        step = (r > 0) ? full / r : 0;
        calc = (r > 0) ? IW + FRAC : 0;
        for (int k = 0; k < calc; k++) push_exp(0, 1'b1, 1'b0, 1'b0);
        for (longint k = 1; k <= r; k++) push_exp((k == r) ? ip : (k * step) >> FRAC, 1'b1, 1'b0, 1'b0);
        for (longint k = 1; k <= h; k++) push_exp(ip, 1'b1, 1'b0, 1'b0);
        for (longint k = 1; k <= f; k++) begin
            v = full - k * step;
            if (v < 0) v = 0;
            push_exp((k == f) ? 0 : v >> FRAC, 1'b1, 1'b0, 1'b0);
        end
        push_exp(0, 1'b0, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_pulse(input logic [15:0] mode, input longint ip, input longint ton,
                             input longint tramp, input int abort_at, input bit junk_en,
                             input int stop_at);
        build_model(mode, ip, ton, tramp);
        if (abort_at > 0 && abort_at <= exp_iset.size()) begin
            while (exp_iset.size() > abort_at) begin
                void'(exp_iset.pop_back()); void'(exp_busy.pop_back());
                void'(exp_done.pop_back()); void'(exp_bad.pop_back());
            end
            push_exp(0, 1'b0, 1'b0, 1'b0);
            push_exp(0, 1'b0, 1'b0, 1'b0);
        end
        obs_iset.delete();
        @(negedge clk);
        waveform = mode; Ip = IW'(ip); Ton_timer = TW'(ton); Tramp = TW'(tramp);
        start = 1'b1; abort = 1'b0;
        for (int c = 1; c <= exp_iset.size(); c++) begin
            @(negedge clk);
            check_eq($sformatf("%h c%0d i_set", mode, c), i_set, exp_iset[c-1]);
            check_eq($sformatf("%h c%0d busy", mode, c), busy, exp_busy[c-1]);
            check_eq($sformatf("%h c%0d done", mode, c), done, exp_done[c-1]);
            check_eq($sformatf("%h c%0d bad_mode", mode, c), bad_mode, exp_bad[c-1]);
            obs_iset.push_back(i_set);
            start = 1'b0;
            abort = (c == abort_at);
            waveform = ($urandom_range(0, 1) == 0) ? 16'h2002 : 16'($urandom);
            Ip = IW'($urandom);
            Ton_timer = TW'($urandom_range(0, 50));
            Tramp = TW'($urandom_range(0, 20));
            if (junk_en && exp_busy[c-1] && c != abort_at && $urandom_range(0, 3) == 0) start = 1'b1;
            if (c == stop_at) return;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    logic [15:0] modes [5];

    initial begin
        modes[0] = 16'h2001; modes[1] = 16'h6001; modes[2] = 16'h2002;
        modes[3] = 16'h2004; modes[4] = 16'h2003;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        waveform = 16'h0000; Ip = 16'd0; Ton_timer = 32'd0; Tramp = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst i_set", i_set, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst bad_mode", bad_mode, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_pulse(16'h2001, 1000, 10, 0, 0, 1'b0, 0);
        check_eq("rect c1", obs_iset[0], 1000);
        check_eq("rect c10", obs_iset[9], 1000);
        check_eq("rect c11", obs_iset[10], 0);

        run_pulse(16'h2002, 800, 8, 0, 0, 1'b0, 0);
        check_eq("tri rise1", obs_iset[32], 200);
        check_eq("tri rise4", obs_iset[35], 800);
        check_eq("tri fall1", obs_iset[36], 600);
        check_eq("tri fall4", obs_iset[39], 0);

        run_pulse(16'h2004, 500, 10, 2, 0, 1'b0, 0);
`ifdef ISET_TRAPEZOID_EN
        check_eq("trap rise1", obs_iset[32], 250);
        check_eq("trap hold", obs_iset[37], 500);
        check_eq("trap fall1", obs_iset[40], 250);
`else
        check_eq("trap off i_set", obs_iset[0], 0);
`endif

        run_pulse(16'h2001, 123, 0, 0, 0, 1'b0, 0);
        run_pulse(16'h2002, 900, 1, 0, 0, 1'b0, 0);
        run_pulse(16'h2004, 640, 10, 6, 0, 1'b0, 0);
        run_pulse(16'h6001, 700, 10, 0, 3, 1'b0, 0);
        run_pulse(16'h2001, 4321, 20, 0, 0, 1'b1, 0);

        run_pulse(16'h2002, 800, 8, 0, 0, 1'b0, 34);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst i_set", i_set, 0);
        check_eq("midrst busy", busy, 0);
        check_eq("midrst done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check_eq("postrst done", done, 0);
            check_eq("postrst busy", busy, 0);
        end
        run_pulse(16'h2002, 800, 8, 0, 0, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] m;
            int ab;
            longint ton_v;
            m = modes[$urandom_range(0, 4)];
            ton_v = $urandom_range(0, 40);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 45)) : 0;
            run_pulse(m, $urandom_range(0, 65535), ton_v, $urandom_range(0, 25), ab, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
